// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and the request legality helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } lsu_state_t;

    // Unsigned variants only make sense for loads; stores never use them.
    function automatic logic f3_legal(input logic [2:0] funct3, input logic write);
        logic ok;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !write;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: merges sub-word store data into
// an existing word, extends load data and flags misaligned accesses.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    input  logic [31:0] read_word,
    output logic [31:0] merged_word,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;

    assign byte_shift = {byte_off, 3'b000};
    assign half_shift = {byte_off[1], 4'b0000};
    assign byte_lane  = read_word[byte_shift +: 8];
    assign half_lane  = read_word[half_shift +: 16];

    always_comb begin
        lane_mask   = '0;
        lane_data   = '0;
        merged_word = store_data;
        load_data   = read_word;
        misaligned  = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                lane_mask   = 32'h0000_00FF << byte_shift;
                lane_data   = {24'h0, store_data[7:0]} << byte_shift;
                merged_word = (old_word & ~lane_mask) | lane_data;
                load_data   = (funct3 == F3_B) ? {{24{byte_lane[7]}}, byte_lane}
                                               : {24'h0, byte_lane};
            end
            F3_H, F3_HU: begin
                lane_mask   = 32'h0000_FFFF << half_shift;
                lane_data   = {16'h0, store_data[15:0]} << half_shift;
                merged_word = (old_word & ~lane_mask) | lane_data;
                load_data   = (funct3 == F3_H) ? {{16{half_lane[15]}}, half_lane}
                                               : {16'h0, half_lane};
                misaligned  = byte_off[0];
            end
            F3_W: begin
                misaligned  = |byte_off;
            end
            default: begin
                misaligned  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-only data memory. Sub-word stores are
// performed as read-modify-write; all core- and memory-facing outputs are registered.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    lsu_state_t  state;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;

    logic [2:0]  align_f3;
    logic [1:0]  align_off;
    logic [31:0] merged_word;
    logic [31:0] load_data;
    logic        misaligned;
    logic        in_range;
    logic        bad_req;
    logic        accept;

    // In IDLE the aligner checks the incoming request; afterwards it works on the captured one.
    assign align_f3  = (state == IDLE) ? req_funct3    : funct3_q;
    assign align_off = (state == IDLE) ? req_addr[1:0] : off_q;

    assign in_range = req_addr[31:2] < WORD_LIMIT;
    assign bad_req  = !f3_legal(req_funct3, req_write) || misaligned || !in_range;
    assign accept   = req_valid && req_ready;

    lsu_align u_align (
        .funct3      (align_f3),
        .byte_off    (align_off),
        .old_word    (mem_rdata),
        .store_data  (wdata_q),
        .read_word   (mem_rdata),
        .merged_word (merged_word),
        .load_data   (load_data),
        .misaligned  (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            write_q    <= 1'b0;
            funct3_q   <= '0;
            off_q      <= '0;
            wdata_q    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        write_q   <= req_write;
                        funct3_q  <= req_funct3;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (bad_req) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            mem_addr <= {req_addr[31:2], 2'b00};
                            // Full-word stores need no read, so they skip straight to the write.
                            if (req_write && (req_funct3 == F3_W)) begin
                                state     <= WR;
                                mem_we    <= 1'b1;
                                mem_wdata <= req_wdata;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    if (write_q) begin
                        state     <= WR;
                        mem_we    <= 1'b1;
                        mem_wdata <= merged_word;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_data;
                    end
                end
                WR: begin
                    state      <= RESP;
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic
// checked against a byte-array reference model of the memory.
module tb_load_store_unit;

    localparam int MEM_WORDS = 32;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    int checks = 0;
    int fails  = 0;

    logic [31:0] last_rdata;
    logic [31:0] last_we_data;
    logic [31:0] last_we_addr;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple word memory the unit talks to.
    assign mem_rdata = (mem_addr[31:2] < 30'(MEM_WORDS)) ? mem[mem_addr[6:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_we && (mem_addr[31:2] < 30'(MEM_WORDS)))
            mem[mem_addr[6:2]] <= mem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Reference: apply the access to ref_mem and predict the unit's response.
    task automatic ref_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] exp_rdata,
                              output logic exp_err, output int exp_lat, output logic [31:0] exp_word);
        logic [7:0] bytes [4];
        logic [31:0] word;
        int b, h, v;
        exp_err = (f3 == 3) || (f3 == 6) || (f3 == 7) || (wr && f3 >= 4)
               || ((f3 == 1 || f3 == 5) && addr[0]) || (f3 == 2 && addr[1:0] != 0)
               || ((addr >> 2) >= MEM_WORDS);
        exp_rdata = 32'h0;
        exp_word  = 32'h0;
        exp_lat   = 1;
        if (!exp_err) begin
            word = ref_mem[addr[6:2]];
            for (int k = 0; k < 4; k++) bytes[k] = word[8*k +: 8];
            b = int'(addr[1:0]);
            h = int'(addr[1]);
            if (wr) begin
                if (f3 == 0) begin
                    bytes[b] = wdata[7:0];
                    exp_lat  = 3;
                end else if (f3 == 1) begin
                    bytes[2*h]   = wdata[7:0];
                    bytes[2*h+1] = wdata[15:8];
                    exp_lat      = 3;
                end else begin
                    exp_lat = 2;
                end
                exp_word = (f3 == 2) ? wdata : {bytes[3], bytes[2], bytes[1], bytes[0]};
                ref_mem[addr[6:2]] = exp_word;
            end else begin
                exp_lat = 2;
                case (f3)
                    0, 4: begin
                        v = int'(bytes[b]);
                        if (f3 == 0 && v >= 128) v -= 256;
                    end
                    1, 5: begin
                        v = int'(bytes[2*h]) + 256 * int'(bytes[2*h+1]);
                        if (f3 == 1 && v >= 32768) v -= 65536;
                    end
                    default: v = int'(word);
                endcase
                exp_rdata = 32'(v);
            end
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        logic [31:0] exp_rdata, exp_word;
        logic exp_err, got_resp, got_err;
        int exp_lat, lat, we_cnt;
        ref_access(wr, f3, addr, wdata, exp_rdata, exp_err, exp_lat, exp_word);
        for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
        checkOutput("ready_before_req", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        lat = 0;
        we_cnt = 0;
        got_resp = 1'b0;
        got_err = 1'b0;
        last_rdata = 32'hx;
        while (!got_resp && lat < 10) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (mem_we) begin
                we_cnt++;
                last_we_addr = mem_addr;
                last_we_data = mem_wdata;
            end
            if (resp_valid) begin
                got_resp   = 1'b1;
                last_rdata = resp_rdata;
                got_err    = resp_err;
            end
        end
        if (!got_resp) lat = 99;
        checkOutput("latency", 32'(lat), 32'(exp_lat));
        checkOutput("resp_rdata", last_rdata, exp_rdata);
        checkOutput("resp_err", 32'(got_err), 32'(exp_err));
        checkOutput("we_count", 32'(we_cnt), (wr && !exp_err) ? 32'd1 : 32'd0);
        if (wr && !exp_err) begin
            checkOutput("we_addr", last_we_addr, {addr[31:2], 2'b00});
            checkOutput("we_data", last_we_data, exp_word);
        end
        @(negedge clk);
        checkOutput("resp_pulse", 32'(resp_valid), 32'd0);
    endtask

    task automatic back_to_back(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] exp_rdata, exp_word;
        logic exp_err;
        int exp_lat;
        ref_access(1'b1, 3'b010, addr, wdata, exp_rdata, exp_err, exp_lat, exp_word);
        ref_access(1'b0, 3'b010, addr, 32'h0, exp_rdata, exp_err, exp_lat, exp_word);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        req_write = 1'b0;
        checkOutput("b2b_ready_wr", 32'(req_ready), 32'd0);
        checkOutput("b2b_we", 32'(mem_we), 32'd1);
        @(negedge clk);
        checkOutput("b2b_ready_resp", 32'(req_ready), 32'd0);
        checkOutput("b2b_sw_resp", 32'(resp_valid), 32'd1);
        @(negedge clk);
        checkOutput("b2b_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("b2b_ready_rd", 32'(req_ready), 32'd0);
        checkOutput("b2b_no_resp_rd", 32'(resp_valid), 32'd0);
        @(negedge clk);
        checkOutput("b2b_lw_resp", 32'(resp_valid), 32'd1);
        checkOutput("b2b_lw_data", resp_rdata, exp_rdata);
        @(negedge clk);
    endtask

    task automatic reset_mid_sh(input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rst_rd_no_we", 32'(mem_we), 32'd0);
        checkOutput("rst_rd_not_ready", 32'(req_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_addr", mem_addr, 32'h0);
        checkOutput("rst_wdata", mem_wdata, 32'h0);
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rst_hold_we", 32'(mem_we), 32'd0);
            checkOutput("rst_hold_resp", 32'(resp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_after_we", 32'(mem_we), 32'd0);
        checkOutput("rst_after_resp", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_rdata", resp_rdata, 32'h0);
        checkOutput("reset_err", 32'(resp_err), 32'd0);
        checkOutput("reset_we", 32'(mem_we), 32'd0);
        checkOutput("reset_addr", mem_addr, 32'h0);
        checkOutput("reset_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
        checkOutput("sw_we_addr_const", last_we_addr, 32'h8);
        applyStimulus(1'b0, 3'b010, 32'h8, 32'h0);
        checkOutput("lw_const", last_rdata, 32'hDEADBEEF);
        applyStimulus(1'b0, 3'b000, 32'h9, 32'h0);
        checkOutput("lb_const", last_rdata, 32'hFFFFFFBE);
        applyStimulus(1'b1, 3'b000, 32'h9, 32'h12345677);
        checkOutput("sb_merge_const", last_we_data, 32'hDEAD77EF);

        applyStimulus(1'b1, 3'b010, 32'h4, 32'h80F17F85);
        applyStimulus(1'b0, 3'b000, 32'h4, 32'h0);
        checkOutput("lb4_const", last_rdata, 32'hFFFFFF85);
        applyStimulus(1'b0, 3'b100, 32'h4, 32'h0);
        checkOutput("lbu4_const", last_rdata, 32'h00000085);
        applyStimulus(1'b0, 3'b000, 32'h5, 32'h0);
        checkOutput("lb5_const", last_rdata, 32'h0000007F);
        applyStimulus(1'b0, 3'b001, 32'h6, 32'h0);
        checkOutput("lh6_const", last_rdata, 32'hFFFF80F1);
        applyStimulus(1'b0, 3'b101, 32'h6, 32'h0);
        checkOutput("lhu6_const", last_rdata, 32'h000080F1);

        applyStimulus(1'b0, 3'b010, 32'h6, 32'h0);
        applyStimulus(1'b1, 3'b001, 32'h3, 32'hFFFF);
        applyStimulus(1'b0, 3'b011, 32'h0, 32'h0);
        applyStimulus(1'b1, 3'b010, 32'(4 * MEM_WORDS), 32'h1234);
        applyStimulus(1'b1, 3'b100, 32'h10, 32'h55);

        back_to_back(32'hC, 32'hCAFEF00D);

        reset_mid_sh(32'h10, 32'hA5A5);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);

        for (int n = 0; n < 150; n++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0)
                addr = 32'(4 * MEM_WORDS) + 32'($urandom_range(0, 1000));
            else
                addr = 32'($urandom_range(0, 4 * MEM_WORDS - 1));
            applyStimulus(wr, f3, addr, $urandom);
        end

        for (int i = 0; i < MEM_WORDS; i++)
            checkOutput("final_mem", mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Processor-side initiator for the word-organised, byte-addressed data memory.
- Accepts RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) from the execute stage through a valid/ready handshake.
- Drives the memory's word-only port. Byte and halfword stores are done as read-modify-write. Load data is extracted and sign- or zero-extended.
- Sits between the core datapath and the data memory. Misaligned or illegal requests are flagged to the core.

Parameters:
- MEM_WORDS, 32, number of memory words; used only for the out-of-range error check.

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address (rs1 + offset)
- req_wdata  in  32  store data (rs2); only the low byte or halfword is used for sub-word stores
- resp_valid  out  1  one-cycle pulse, response complete
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal funct3 or out-of-range; qualified by resp_valid
- mem_addr  out  32  word-aligned byte address {addr[31:2],2'b00}
- mem_we  out  1  memory write enable, high for exactly one cycle per store
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  combinational read data for mem_addr

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - req_ready=1 after reset; resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - All captured request registers clear.
- Accept: at the rising edge where req_valid && req_ready, the unit captures write, funct3, addr and wdata. Request inputs are don't-care in other cycles.
- States: IDLE, RD, WR, RESP.
  - IDLE: on accept, go to RESP with error if the request is bad. Otherwise go to WR for SW and RD for everything else.
  - RD: mem_addr driven; mem_rdata registered at the end of the cycle. Loads go to RESP; SB/SH go to WR.
  - WR: mem_we=1 and mem_addr driven. mem_wdata is req_wdata for SW, or the merged word for SB/SH; then go to RESP.
  - RESP: resp_valid=1 for one cycle, then IDLE. req_ready=0 in RESP.
- Latency, counted from the accept edge to the resp_valid cycle:
  - loads: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - errors: 1 cycle
- Throughput: a new request can be accepted in the cycle after RESP.
- Error conditions (resp_err=1, no mem_we ever asserted, resp_rdata=0):
  - H/HU with addr[0]=1
  - W with addr[1:0]≠0
  - funct3 ∈ {011,110,111}
  - a store with funct3[2]=1
  - addr[31:2] ≥ MEM_WORDS
- Byte lane: b = addr[1:0]; byte b occupies bits [8b+7:8b]. A halfword uses lane addr[1] at bits [16h+15:16h].
- Merge: only the addressed lane is replaced with req_wdata[7:0] or [15:0]; all other bits keep their RD-cycle values.
- Load extension:
  - LB/LH: sign-extend from bit 7 or bit 15 of the lane.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- Reset mid-operation: the operation is abandoned with no memory write and no response. The core must reissue.
- mem_addr holds its last value in IDLE. mem_we is 0 in every state except WR.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum lsu_state_t {IDLE, RD, WR, RESP}
- Sub-module lsu_align, combinational:
  - inputs: funct3, addr[1:0], old word, store data, read word
  - outputs: merged store word, extended load data, misalignment flag
  - The FSM stays in load_store_unit.

Test Plan:
- SW addr=0x8, wdata=0xDEADBEEF → WR cycle with mem_we=1, mem_addr=0x8; resp_valid 2 cycles after accept; a subsequent LW 0x8 returns 0xDEADBEEF, err=0.
- Word 0x8 holds 0xDEADBEEF; SB addr=0x9, wdata=0x12345677 → RD then WR with mem_wdata=0xDEAD77EF; latency 3 cycles.
- Word 0x4 holds 0x80F1_7F85:
  - LB 0x4 → 0xFFFFFF85
  - LBU 0x4 → 0x00000085
  - LB 0x5 → 0x0000007F
  - LH 0x6 → 0xFFFF80F1
  - LHU 0x6 → 0x000080F1
- LW 0x6, SH 0x3 and funct3=011 → each gives resp_err=1 one cycle after accept, resp_rdata=0, mem_we never high; SW addr=4*MEM_WORDS → err=1.
- Back-to-back: req_valid held high with SW then LW → req_ready low in RD/WR/RESP; the second request is accepted the cycle after RESP and returns the stored value.
- rst_n pulsed low during the RD cycle of an SH → no mem_we and no resp_valid; outputs return to reset values; target word unchanged.
